// File: rtl/soc_master_arbiter_if.sv
// Request bundle between the SoC masters and one crossbar address channel.
// Modport slave is the arbiter side; modport master is the requesting/driving side.
interface soc_master_arbiter_if #(
    parameter int unsigned NumMst    = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4
);
    localparam int unsigned IdxW = $clog2(NumMst);

    logic [NumMst-1:0]           mst_valid_i;
    logic [NumMst-1:0]           mst_ready_o;
    logic [NumMst*AddrWidth-1:0] mst_addr_i;
    logic [NumMst*IdWidth-1:0]   mst_id_i;
    logic                        slv_valid_o;
    logic                        slv_ready_i;
    logic [AddrWidth-1:0]        slv_addr_o;
    logic [IdWidth+IdxW-1:0]     slv_id_o;
    logic                        rsp_done_i;
    logic [IdxW-1:0]             rsp_mst_i;
    logic                        busy_o;
    logic                        err_o;

    modport slave (
        input  mst_valid_i, mst_addr_i, mst_id_i, slv_ready_i, rsp_done_i, rsp_mst_i,
        output mst_ready_o, slv_valid_o, slv_addr_o, slv_id_o, busy_o, err_o
    );

    modport master (
        output mst_valid_i, mst_addr_i, mst_id_i, slv_ready_i, rsp_done_i, rsp_mst_i,
        input  mst_ready_o, slv_valid_o, slv_addr_o, slv_id_o, busy_o, err_o
    );
endinterface

// File: rtl/soc_master_arbiter.sv
// Round-robin arbiter with outstanding limits and starvation override; optional SOC_MASTER_ARB_PERF_CNT_EN grant counters.
// Latency: one cycle from mst_valid_i to slv_valid_o; one grant per cycle when slv_ready_i stays high.
// Backpressure: while slv_valid_o && !slv_ready_i the stage holds addr/ID and mst_ready_o stays zero.
module soc_master_arbiter #(
    parameter int unsigned NumMst         = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned StarveLimit    = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    soc_master_arbiter_if.slave bus
`ifdef SOC_MASTER_ARB_PERF_CNT_EN
    ,
    input  logic                 perf_clr_i,
    output logic [NumMst*32-1:0] perf_grant_o
`endif
);
    localparam int unsigned IdxW = $clog2(NumMst);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned StvW = $clog2(StarveLimit + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q    [NumMst];
    logic [StvW-1:0]         starve_q [NumMst];
    logic [IdxW-1:0]         rr_q;
    logic [AddrWidth-1:0]    addr_q;
    logic [IdxW+IdWidth-1:0] id_q;
    logic                    err_q;

    logic [NumMst-1:0] eligible, starved, inc_v, dec_v, nz_v;
    logic              stage_free, grant, err_hit;
    logic [IdxW-1:0]   winner, idx;

    always_comb begin
        eligible = '0;
        starved  = '0;
        for (int i = 0; i < NumMst; i++) begin
            eligible[i] = bus.mst_valid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
            starved[i]  = eligible[i] && (starve_q[i] >= StvW'(StarveLimit));
        end
    end

    // Descending loops so the last hit is the lowest index / nearest to the pointer.
    always_comb begin
        winner = '0;
        idx    = '0;
        if (|starved) begin
            for (int i = NumMst - 1; i >= 0; i--) begin
                if (starved[i]) winner = IdxW'(i);
            end
        end else begin
            for (int k = NumMst - 1; k >= 0; k--) begin
                idx = IdxW'((int'(rr_q) + k) % int'(NumMst));
                if (eligible[idx]) winner = idx;
            end
        end
    end

    assign stage_free = (state_q == IDLE) || bus.slv_ready_i;
    assign grant      = stage_free && (|eligible);

    always_comb begin
        bus.mst_ready_o = '0;
        if (grant) bus.mst_ready_o[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (stage_free) state_d = (|eligible) ? HOLD : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            id_q   <= '0;
            rr_q   <= '0;
        end else if (grant) begin
            addr_q <= bus.mst_addr_i[winner*AddrWidth +: AddrWidth];
            id_q   <= {winner, bus.mst_id_i[winner*IdWidth +: IdWidth]};
            rr_q   <= (winner == IdxW'(NumMst - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        inc_v   = '0;
        dec_v   = '0;
        nz_v    = '0;
        err_hit = 1'b0;
        for (int i = 0; i < NumMst; i++) begin
            inc_v[i] = grant && (winner == IdxW'(i));
            dec_v[i] = bus.rsp_done_i && (bus.rsp_mst_i == IdxW'(i));
            nz_v[i]  = (cnt_q[i] != '0);
            err_hit  = err_hit || (dec_v[i] && !nz_v[i]);
        end
    end

    // A grant and a completion for the same master cancel; a completion at zero only flags err.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumMst; i++) begin
                cnt_q[i]    <= '0;
                starve_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumMst; i++) begin
                if (inc_v[i] && !dec_v[i])
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (dec_v[i] && !inc_v[i] && nz_v[i])
                    cnt_q[i] <= cnt_q[i] - 1'b1;

                if (!bus.mst_valid_i[i] || inc_v[i])
                    starve_q[i] <= '0;
                else if (eligible[i] && (starve_q[i] < StvW'(StarveLimit)))
                    starve_q[i] <= starve_q[i] + 1'b1;
            end
            if (err_hit) err_q <= 1'b1;
        end
    end

    assign bus.slv_valid_o = (state_q == HOLD);
    assign bus.slv_addr_o  = addr_q;
    assign bus.slv_id_o    = id_q;
    assign bus.busy_o      = (|nz_v) || (state_q == HOLD);
    assign bus.err_o       = err_q;

`ifdef SOC_MASTER_ARB_PERF_CNT_EN
    logic [31:0] perf_q [NumMst];

    // Clear takes priority over a same-cycle grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumMst; i++) perf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumMst; i++) begin
                if (perf_clr_i)    perf_q[i] <= '0;
                else if (inc_v[i]) perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        perf_grant_o = '0;
        for (int i = 0; i < NumMst; i++) perf_grant_o[i*32 +: 32] = perf_q[i];
    end
`endif

endmodule

// File: tb/tb_soc_master_arbiter.sv
// Directed self-checking bench for soc_master_arbiter (MaxOutstanding=2, StarveLimit=4).
module tb_soc_master_arbiter;
    localparam int NM  = 4;
    localparam int AW  = 64;
    localparam int IW  = 4;
    localparam int MO  = 2;
    localparam int SL  = 4;
    localparam int IDW = IW + 2;

    logic clk_i;
    logic rst_ni;
    int   checks = 0;
    int   passes = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    soc_master_arbiter_if #(.NumMst(NM), .AddrWidth(AW), .IdWidth(IW)) bus ();

`ifdef SOC_MASTER_ARB_PERF_CNT_EN
    logic          perf_clr_i;
    logic [NM*32-1:0] perf_grant_o;
`endif

    soc_master_arbiter #(
        .NumMst(NM), .AddrWidth(AW), .IdWidth(IW), .MaxOutstanding(MO), .StarveLimit(SL)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
`ifdef SOC_MASTER_ARB_PERF_CNT_EN
        ,
        .perf_clr_i   (perf_clr_i),
        .perf_grant_o (perf_grant_o)
`endif
    );

    function automatic logic [AW-1:0] addr_of(input int i);
        return 64'hA000_0000 + 64'(i) * 64'h40;
    endfunction

    function automatic logic [IW-1:0] id_of(input int i);
        return IW'(i + 8);
    endfunction

    task automatic clear_inputs();
        bus.mst_valid_i = '0;
        bus.mst_addr_i  = '0;
        bus.mst_id_i    = '0;
        bus.slv_ready_i = 1'b0;
        bus.rsp_done_i  = 1'b0;
        bus.rsp_mst_i   = '0;
`ifdef SOC_MASTER_ARB_PERF_CNT_EN
        perf_clr_i = 1'b0;
`endif
    endtask

    task automatic set_req(input int i);
        bus.mst_addr_i[i*AW +: AW] = addr_of(i);
        bus.mst_id_i[i*IW +: IW]   = id_of(i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL rst_slv_valid: got %b exp 0", bus.slv_valid_o); else passes++;
        checks++; if (bus.slv_addr_o !== '0) $display("FAIL rst_slv_addr: got %h exp 0", bus.slv_addr_o); else passes++;
        checks++; if (bus.slv_id_o !== '0) $display("FAIL rst_slv_id: got %h exp 0", bus.slv_id_o); else passes++;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0000) $display("FAIL rst_mst_ready: got %b exp 0000", bus.mst_ready_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b exp 0", bus.busy_o); else passes++;
        checks++; if (bus.err_o !== 1'b0) $display("FAIL rst_err: got %b exp 0", bus.err_o); else passes++;
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL idle_slv_valid: got %b exp 0", bus.slv_valid_o); else passes++;
    endtask

    task automatic test_single();
        do_reset();
        bus.mst_valid_i = 4'b0010;
        bus.mst_addr_i[1*AW +: AW] = 64'h1000_0000;
        bus.mst_id_i[1*IW +: IW]   = 4'd3;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0010) $display("FAIL single_ready: got %b exp 0010", bus.mst_ready_o); else passes++;
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL single_valid_early: got %b exp 0", bus.slv_valid_o); else passes++;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0000;
        #1;
        checks++; if (bus.slv_valid_o !== 1'b1) $display("FAIL single_valid: got %b exp 1", bus.slv_valid_o); else passes++;
        checks++; if (bus.slv_addr_o !== 64'h1000_0000) $display("FAIL single_addr: got %h exp 10000000", bus.slv_addr_o); else passes++;
        checks++; if (bus.slv_id_o !== 6'h13) $display("FAIL single_id: got %h exp 13", bus.slv_id_o); else passes++;
        checks++; if (bus.busy_o !== 1'b1) $display("FAIL single_busy: got %b exp 1", bus.busy_o); else passes++;
        bus.slv_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL single_drain: got %b exp 0", bus.slv_valid_o); else passes++;
        checks++; if (bus.busy_o !== 1'b1) $display("FAIL single_busy_cnt: got %b exp 1", bus.busy_o); else passes++;
        bus.rsp_done_i = 1'b1;
        bus.rsp_mst_i  = 2'd1;
        @(negedge clk_i);
        bus.rsp_done_i = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL single_busy_done: got %b exp 0", bus.busy_o); else passes++;
        checks++; if (bus.err_o !== 1'b0) $display("FAIL single_err: got %b exp 0", bus.err_o); else passes++;
    endtask

    task automatic test_round_robin();
        logic [NM-1:0]  exp_rdy;
        logic [IDW-1:0] exp_id;
        do_reset();
        for (int i = 0; i < NM; i++) set_req(i);
        bus.mst_valid_i = 4'b1111;
        bus.slv_ready_i = 1'b1;
        for (int k = 0; k < MO * NM; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % NM);
            checks++; if (bus.mst_ready_o !== exp_rdy) $display("FAIL rr_ready[%0d]: got %b exp %b", k, bus.mst_ready_o, exp_rdy); else passes++;
            if (k > 0) begin
                exp_id = {2'((k - 1) % NM), id_of((k - 1) % NM)};
                checks++; if (bus.slv_id_o !== exp_id) $display("FAIL rr_id[%0d]: got %h exp %h", k, bus.slv_id_o, exp_id); else passes++;
            end
            @(negedge clk_i);
        end
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0000) $display("FAIL rr_capped_ready: got %b exp 0000", bus.mst_ready_o); else passes++;
        checks++; if (bus.slv_addr_o !== addr_of(3)) $display("FAIL rr_last_addr: got %h exp %h", bus.slv_addr_o, addr_of(3)); else passes++;
        @(negedge clk_i);
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL rr_capped_valid: got %b exp 0", bus.slv_valid_o); else passes++;
        checks++; if (bus.busy_o !== 1'b1) $display("FAIL rr_busy: got %b exp 1", bus.busy_o); else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0);
        set_req(2);
        bus.mst_valid_i = 4'b0001;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0001) $display("FAIL bp_first_ready: got %b exp 0001", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (bus.mst_ready_o !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b exp 0000", k, bus.mst_ready_o); else passes++;
            checks++; if (bus.slv_valid_o !== 1'b1) $display("FAIL bp_valid[%0d]: got %b exp 1", k, bus.slv_valid_o); else passes++;
            checks++; if (bus.slv_addr_o !== addr_of(0)) $display("FAIL bp_addr[%0d]: got %h exp %h", k, bus.slv_addr_o, addr_of(0)); else passes++;
            checks++; if (bus.slv_id_o !== {2'd0, id_of(0)}) $display("FAIL bp_id[%0d]: got %h exp %h", k, bus.slv_id_o, {2'd0, id_of(0)}); else passes++;
            @(negedge clk_i);
        end
        bus.slv_ready_i = 1'b1;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0100) $display("FAIL bp_resume_ready: got %b exp 0100", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0000;
        checks++; if (bus.slv_addr_o !== addr_of(2)) $display("FAIL bp_resume_addr: got %h exp %h", bus.slv_addr_o, addr_of(2)); else passes++;
    endtask

    task automatic test_outstanding();
        do_reset();
        set_req(0);
        set_req(3);
        bus.mst_valid_i = 4'b1000;
        bus.slv_ready_i = 1'b1;
        for (int k = 0; k < MO; k++) begin
            #1;
            checks++; if (bus.mst_ready_o !== 4'b1000) $display("FAIL os_issue[%0d]: got %b exp 1000", k, bus.mst_ready_o); else passes++;
            @(negedge clk_i);
        end
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0000) $display("FAIL os_masked: got %b exp 0000", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL os_drained: got %b exp 0", bus.slv_valid_o); else passes++;
        bus.rsp_done_i = 1'b1;
        bus.rsp_mst_i  = 2'd3;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0000) $display("FAIL os_rsp_cycle: got %b exp 0000", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.rsp_done_i = 1'b0;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b1000) $display("FAIL os_unmasked: got %b exp 1000", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0001;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0001) $display("FAIL os_m0_first: got %b exp 0001", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.rsp_done_i = 1'b1;
        bus.rsp_mst_i  = 2'd0;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0001) $display("FAIL os_m0_same_cycle: got %b exp 0001", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.rsp_done_i = 1'b0;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0001) $display("FAIL os_m0_second: got %b exp 0001", bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        #1;
        checks++; if (bus.mst_ready_o !== 4'b0000) $display("FAIL os_m0_capped: got %b exp 0000", bus.mst_ready_o); else passes++;
        checks++; if (bus.err_o !== 1'b0) $display("FAIL os_err: got %b exp 0", bus.err_o); else passes++;
        bus.mst_valid_i = 4'b0000;
    endtask

    task automatic test_starvation(input int wait_cyc, input int first, input int second);
        logic [NM-1:0]  exp_rdy;
        logic [IDW-1:0] exp_id;
        do_reset();
        set_req(0);
        set_req(2);
        set_req(3);
        bus.mst_valid_i = 4'b1000;
        #1;
        checks++; if (bus.mst_ready_o !== 4'b1000) $display("FAIL stv%0d_m3: got %b exp 1000", wait_cyc, bus.mst_ready_o); else passes++;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0100;
        repeat (wait_cyc) @(negedge clk_i);
        bus.mst_valid_i = 4'b0101;
        bus.slv_ready_i = 1'b1;
        #1;
        exp_rdy = 4'b0001 << first;
        checks++; if (bus.mst_ready_o !== exp_rdy) $display("FAIL stv%0d_first: got %b exp %b", wait_cyc, bus.mst_ready_o, exp_rdy); else passes++;
        @(negedge clk_i);
        exp_id = {2'(first), id_of(first)};
        checks++; if (bus.slv_id_o !== exp_id) $display("FAIL stv%0d_id: got %h exp %h", wait_cyc, bus.slv_id_o, exp_id); else passes++;
        #1;
        exp_rdy = 4'b0001 << second;
        checks++; if (bus.mst_ready_o !== exp_rdy) $display("FAIL stv%0d_second: got %b exp %b", wait_cyc, bus.mst_ready_o, exp_rdy); else passes++;
        bus.mst_valid_i = 4'b0000;
    endtask

    task automatic test_error();
        do_reset();
        bus.rsp_done_i = 1'b1;
        bus.rsp_mst_i  = 2'd1;
        @(negedge clk_i);
        bus.rsp_done_i = 1'b0;
        checks++; if (bus.err_o !== 1'b1) $display("FAIL err_set: got %b exp 1", bus.err_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL err_busy: got %b exp 0", bus.busy_o); else passes++;
        repeat (3) @(negedge clk_i);
        checks++; if (bus.err_o !== 1'b1) $display("FAIL err_sticky: got %b exp 1", bus.err_o); else passes++;
    endtask

    // Runs straight after test_error so the sticky flag is still set going in.
    task automatic test_reset_mid_hold();
        set_req(1);
        bus.mst_valid_i = 4'b0010;
        bus.slv_ready_i = 1'b0;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0000;
        checks++; if (bus.slv_valid_o !== 1'b1) $display("FAIL mid_hold_valid: got %b exp 1", bus.slv_valid_o); else passes++;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.slv_valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b exp 0", bus.slv_valid_o); else passes++;
        checks++; if (bus.slv_addr_o !== '0) $display("FAIL mid_rst_addr: got %h exp 0", bus.slv_addr_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL mid_rst_busy: got %b exp 0", bus.busy_o); else passes++;
        checks++; if (bus.err_o !== 1'b0) $display("FAIL mid_rst_err: got %b exp 0", bus.err_o); else passes++;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

`ifdef SOC_MASTER_ARB_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        set_req(0);
        bus.mst_valid_i = 4'b0001;
        bus.slv_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.rsp_done_i = (k > 0);
            bus.rsp_mst_i  = 2'd0;
            @(negedge clk_i);
        end
        bus.mst_valid_i = 4'b0000;
        bus.rsp_done_i  = 1'b0;
        #1;
        checks++; if (perf_grant_o[31:0] !== 32'd10) $display("FAIL perf_m0: got %0d exp 10", perf_grant_o[31:0]); else passes++;
        checks++; if (perf_grant_o[63:32] !== 32'd0) $display("FAIL perf_m1: got %0d exp 0", perf_grant_o[63:32]); else passes++;
        bus.mst_valid_i = 4'b0001;
        perf_clr_i      = 1'b1;
        @(negedge clk_i);
        bus.mst_valid_i = 4'b0000;
        perf_clr_i      = 1'b0;
        #1;
        checks++; if (perf_grant_o[31:0] !== 32'd0) $display("FAIL perf_clr: got %0d exp 0", perf_grant_o[31:0]); else passes++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_outstanding();
        test_starvation(4, 2, 0);
        test_starvation(3, 0, 2);
        test_error();
        test_reset_mid_hold();
`ifdef SOC_MASTER_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
